// File: rtl/t07_fpu_iter_mul.sv
// Iterative binary32 multiplier: operands come from the FPU register file, the result goes to its write port.
// Latency: 27 cycles from start to done for normal operands; 2 cycles when a NaN, inf or zero operand takes the shortcut.
// Backpressure: none. freeze_o stalls the core while an operation is in flight, and start_i is ignored unless IDLE.
module t07_fpu_iter_mul #(
  parameter int          MUL_CYCLES = 24,
  parameter logic [31:0] CANON_NAN  = 32'h7FC00000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic [4:0]  rd_i,
  output logic        busy_o,
  output logic        freeze_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_o,
  output logic        FPUregWrite_o,
  output logic [3:0]  flags_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_MUL    = 3'd2,
    S_NORM   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [4:0] LAST_ITER = 5'(MUL_CYCLES - 1);

  state_t      state;
  logic [31:0] a_r, b_r;
  logic [4:0]  rd_r;
  logic [47:0] mcand;
  logic [23:0] mplier;
  logic [47:0] prod;
  logic [4:0]  cnt;

  // Operand classification; denormals flush to zero so exponent 0 means zero.
  logic [7:0]  ea, eb;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign;
  logic [23:0] ma, mb;
  logic        spec_hit, spec_nv;
  logic [31:0] spec_res;

  // Decode captured operands and resolve the special-case shortcut.
  always_comb begin
    ea       = a_r[30:23];
    eb       = b_r[30:23];
    sign     = a_r[31] ^ b_r[31];
    a_zero   = (ea == 8'h00);
    b_zero   = (eb == 8'h00);
    a_nan    = (ea == 8'hFF) && (a_r[22:0] != 23'd0);
    b_nan    = (eb == 8'hFF) && (b_r[22:0] != 23'd0);
    a_inf    = (ea == 8'hFF) && (a_r[22:0] == 23'd0);
    b_inf    = (eb == 8'hFF) && (b_r[22:0] == 23'd0);
    ma       = a_zero ? 24'd0 : {1'b1, a_r[22:0]};
    mb       = b_zero ? 24'd0 : {1'b1, b_r[22:0]};
    spec_hit = 1'b1;
    spec_nv  = 1'b0;
    spec_res = 32'd0;
    if (a_nan || b_nan) begin
      spec_res = CANON_NAN;
      spec_nv  = (a_nan && !a_r[22]) || (b_nan && !b_r[22]);
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res = CANON_NAN;
      spec_nv  = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      spec_res = {sign, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalise the 48-bit product, round to nearest even, then clamp to inf or zero.
  logic [9:0]  e_base, e_n, e_fin;
  logic [22:0] m_pre, m_rnd;
  logic        g_bit, s_bit, rnd_up, m_carry, ovf, unf;
  logic [31:0] norm_res;
  logic [3:0]  norm_flags;

  always_comb begin
    e_base = {2'b00, ea} + {2'b00, eb} - 10'd127;
    if (prod[47]) begin
      m_pre = prod[46:24];
      g_bit = prod[23];
      s_bit = |prod[22:0];
      e_n   = e_base + 10'd1;
    end else begin
      m_pre = prod[45:23];
      g_bit = prod[22];
      s_bit = |prod[21:0];
      e_n   = e_base;
    end
    rnd_up             = g_bit & (s_bit | m_pre[0]);
    {m_carry, m_rnd}   = {1'b0, m_pre} + {23'd0, rnd_up};
    e_fin              = e_n + {9'd0, m_carry};
    // e_fin is two's complement; bit 9 set means the exponent went negative.
    ovf = !e_fin[9] && (e_fin >= 10'd255);
    unf = e_fin[9] || (e_fin == 10'd0);
    if (ovf) begin
      norm_res   = {sign, 8'hFF, 23'd0};
      norm_flags = 4'b0101;
    end else if (unf) begin
      norm_res   = {sign, 31'd0};
      norm_flags = 4'b0011;
    end else begin
      norm_res   = {sign, e_fin[7:0], m_rnd};
      norm_flags = {3'b000, g_bit | s_bit};
    end
  end

  // Control FSM with the shift-add datapath and registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      rd_r     <= 5'd0;
      mcand    <= 48'd0;
      mplier   <= 24'd0;
      prod     <= 48'd0;
      cnt      <= 5'd0;
      done_o   <= 1'b0;
      result_o <= 32'd0;
      rd_o     <= 5'd0;
      flags_o  <= 4'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_r   <= op_a_i;
            b_r   <= op_b_i;
            rd_r  <= rd_i;
            state <= S_UNPACK;
          end
        end
        S_UNPACK: begin
          if (spec_hit) begin
            result_o <= spec_res;
            flags_o  <= {spec_nv, 3'b000};
            rd_o     <= rd_r;
            done_o   <= 1'b1;
            state    <= S_DONE;
          end else begin
            mcand  <= {24'd0, ma};
            mplier <= mb;
            prod   <= 48'd0;
            cnt    <= 5'd0;
            state  <= S_MUL;
          end
        end
        S_MUL: begin
          // Multiplier consumed LSB first; multiplicand shifts up to match bit weight.
          prod   <= prod + (mplier[0] ? mcand : 48'd0);
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= S_NORM;
        end
        S_NORM: begin
          result_o <= norm_res;
          flags_o  <= norm_flags;
          rd_o     <= rd_r;
          done_o   <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Freeze drops in DONE so the pipeline advances during the write cycle.
  assign busy_o        = (state != S_IDLE);
  assign freeze_o      = ((state == S_IDLE) && start_i) || (state == S_UNPACK) ||
                         (state == S_MUL) || (state == S_NORM);
  assign FPUregWrite_o = done_o;

endmodule

// File: tb/tb_t07_fpu_iter_mul.sv
// Bench for the iterative binary32 multiplier: directed cases, then random operands against a reference model.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Cycle numbering: cycle 0 is the cycle in which start_i is high.
module tb_t07_fpu_iter_mul;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  rd_i;
  logic        busy_o, freeze_o, done_o, FPUregWrite_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;
  logic [3:0]  flags_o;

  int tests = 0;
  int fails = 0;

  t07_fpu_iter_mul dut (
    .clk(clk), .rst(rst), .start_i(start_i), .op_a_i(op_a_i), .op_b_i(op_b_i),
    .rd_i(rd_i), .busy_o(busy_o), .freeze_o(freeze_o), .done_o(done_o),
    .result_o(result_o), .rd_o(rd_o), .FPUregWrite_o(FPUregWrite_o), .flags_o(flags_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: {shortcut, flags{nv,of,uf,nx}, result}. The exact product is rounded
  // by comparing the discarded remainder against half an ulp.
  function automatic logic [36:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, msb, sh;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, inexact;
    logic [63:0] p, q, rem, half;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sgn    = a[31] ^ b[31];
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan)
      return {1'b1, (a_nan && !a[22]) || (b_nan && !b[22]), 3'b000, 32'h7FC00000};
    if ((a_inf && b_zero) || (b_inf && a_zero))
      return {1'b1, 4'b1000, 32'h7FC00000};
    if (a_inf || b_inf)
      return {1'b1, 4'b0000, sgn, 8'hFF, 23'd0};
    if (a_zero || b_zero)
      return {1'b1, 4'b0000, sgn, 31'd0};
    p    = {40'd0, 1'b1, a[22:0]} * {40'd0, 1'b1, b[22:0]};
    msb  = (p >= (64'd1 << 47)) ? 47 : 46;
    sh   = msb - 23;
    q    = p >> sh;
    rem  = p - (q << sh);
    half = 64'd1 << (sh - 1);
    inexact = (rem != 0);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    e = ea + eb - 127 + (msb - 46);
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {1'b0, 4'b0101, sgn, 8'hFF, 23'd0};
    if (e <= 0)   return {1'b0, 4'b0011, sgn, 31'd0};
    return {1'b0, 3'b000, inexact, sgn, e[7:0], q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    int r;
    logic [7:0]  e;
    logic [22:0] f;
    r = int'($urandom_range(0, 19));
    f = 23'($urandom);
    case (r)
      0:       e = 8'h00;
      1:       begin e = 8'hFF; f = 23'd0; end
      2:       begin e = 8'hFF; if (f == 23'd0) f = 23'd1; end
      3:       e = 8'($urandom_range(1, 254));
      4:       e = 8'($urandom_range(1, 12));
      5:       e = 8'($urandom_range(243, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, f};
  endfunction

  // One operation with start_i pulsed for cycle 0 only; operands are scrambled afterwards.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] exp_res,
                        input logic [3:0] exp_flags, input int lat);
    int done_at, pulses, frz_bad, wr_bad;
    done_at = -1; pulses = 0; frz_bad = 0; wr_bad = 0;
    @(negedge clk);
    start_i = 1'b1; op_a_i = a; op_b_i = b; rd_i = rd;
    #1;
    if (freeze_o !== 1'b1) frz_bad++;
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        pulses++;
        if (done_at < 0) done_at = c;
      end
      if (FPUregWrite_o !== done_o) wr_bad++;
      if (freeze_o !== ((c < lat) ? 1'b1 : 1'b0)) frz_bad++;
      if (c == lat) begin
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " rd"}, rd_o, rd);
        chk({tag, " flags"}, flags_o, exp_flags);
      end
      if (c == lat + 1) begin
        chk({tag, " busy idle"}, busy_o, 1'b0);
        chk({tag, " result held"}, result_o, exp_res);
      end
      start_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; rd_i = 5'($urandom);
    end
    chk({tag, " done cycle"}, done_at, lat);
    chk({tag, " done pulses"}, pulses, 1);
    chk({tag, " freeze pattern"}, frz_bad, 0);
    chk({tag, " write strobe"}, wr_bad, 0);
  endtask

  initial begin
    int dcyc[$];
    logic [31:0] dres[$];
    logic [4:0]  drd[$];
    int pulses;
    logic [31:0] a, b;
    logic [36:0] m;

    rst = 1'b1; start_i = 1'b0; op_a_i = 32'd0; op_b_i = 32'd0; rd_i = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset busy", busy_o, 1'b0);
    chk("reset freeze", freeze_o, 1'b0);
    chk("reset done", done_o, 1'b0);
    chk("reset wr", FPUregWrite_o, 1'b0);
    chk("reset outputs", {result_o, rd_o, flags_o}, 41'd0);
    rst = 1'b0;

    run_op("1.5x2",     32'h3FC00000, 32'h40000000, 5'd5,  32'h40400000, 4'b0000, 27);
    run_op("round nx",  32'h3F800001, 32'h3F800001, 5'd3,  32'h3F800002, 4'b0001, 27);
    run_op("overflow",  32'h7F000000, 32'h7F000000, 5'd12, 32'h7F800000, 4'b0101, 27);
    run_op("underflow", 32'h00800000, 32'h3F000000, 5'd1,  32'h00000000, 4'b0011, 27);
    run_op("inf x 0",   32'h7F800000, 32'h00000000, 5'd31, 32'h7FC00000, 4'b1000, 2);
    run_op("-inf x 2",  32'hFF800000, 32'h40000000, 5'd0,  32'hFF800000, 4'b0000, 2);
    run_op("snan",      32'h7F800001, 32'h3F800000, 5'd7,  32'h7FC00000, 4'b1000, 2);
    run_op("round up",  32'h3FFFFFFF, 32'h3FFFFFFF, 5'd9,  32'h407FFFFE, 4'b0001, 27);

    // start_i held high: the second op is taken in cycle 28 with the operands present then.
    @(negedge clk);
    start_i = 1'b1; op_a_i = 32'h3FC00000; op_b_i = 32'h40000000; rd_i = 5'd7;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        dcyc.push_back(c); dres.push_back(result_o); drd.push_back(rd_o);
      end
      if (c == 1) begin op_a_i = 32'h3F800001; op_b_i = 32'h3F800001; rd_i = 5'd9; end
      if (c == 29) start_i = 1'b0;
    end
    chk("held dones", dcyc.size(), 2);
    if (dcyc.size() == 2) begin
      chk("held done0 cycle", dcyc[0], 27);
      chk("held done0 result", dres[0], 32'h40400000);
      chk("held done0 rd", drd[0], 5'd7);
      chk("held done1 cycle", dcyc[1], 55);
      chk("held done1 result", dres[1], 32'h3F800002);
      chk("held done1 rd", drd[1], 5'd9);
    end

    // Reset mid-operation discards the op and clears every output.
    @(negedge clk);
    start_i = 1'b1; op_a_i = 32'h40400000; op_b_i = 32'h40A00000; rd_i = 5'd4;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start_i = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", busy_o, 1'b0);
    chk("midrst freeze", freeze_o, 1'b0);
    chk("midrst outputs", {done_o, FPUregWrite_o, result_o, rd_o, flags_o}, 43'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done_o === 1'b1 || FPUregWrite_o === 1'b1) pulses++;
    end
    chk("midrst no write", pulses, 0);

    for (int i = 0; i < 40; i++) begin
      a = rand_op();
      b = rand_op();
      m = ref_mul(a, b);
      run_op($sformatf("rand%0d %h*%h", i, a, b), a, b, 5'($urandom), m[31:0], m[35:32],
             m[36] ? 2 : 27);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end
endmodule
